paddle_input_ctrl: RTL and testbench

PADDLE_INPUT_CTRL -- requirements
Module: paddle_input_ctrl

---
 rtl/breakout_pkg.sv | 21 ++
 rtl/input_sync.sv | 25 ++
 rtl/paddle_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_paddle_input_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared playfield geometry, level limits and paddle direction encoding for
// the breakout game blocks.
package breakout_pkg;

  localparam int SCREEN_W = 640;
  localparam int PADDLE_W = 64;
  localparam int POS_W    = 10;
  localparam int LVL_W    = 4;

  localparam logic [LVL_W-1:0] LVL_MIN = 4'd1;
  localparam logic [LVL_W-1:0] LVL_MAX = 4'd8;

  localparam logic [1:0] DIR_IDLE  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;

  function automatic logic lvl_valid(input logic [LVL_W-1:0] lvl);
    return (lvl >= LVL_MIN) && (lvl <= LVL_MAX);
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for a bundle of independent slow asynchronous bits
// (keyboard keys); each bit is synchronized on its own.
module input_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep meta->q a true two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Keyboard-driven paddle controller: synchronizes the keys, generates the
// movement tick, steers the paddle and hands level changes to the game FSM.
module paddle_input_ctrl #(
  parameter int TICK_DIV   = 833333,
  parameter int SCREEN_W   = breakout_pkg::SCREEN_W,
  parameter int PADDLE_W   = breakout_pkg::PADDLE_W,
  parameter int STEP       = 4,
  parameter int LVL_STABLE = 3
) (
  input  logic                          CLK,
  input  logic                          CPU_RESETN,
  input  logic                          move_left,
  input  logic                          move_right,
  input  logic [breakout_pkg::LVL_W-1:0] level,
  input  logic                          game_running,
  input  logic                          lvl_ack,
  output logic [breakout_pkg::POS_W-1:0] paddle_x,
  output logic                          frame_tick,
  output logic                          lvl_req,
  output logic [breakout_pkg::LVL_W-1:0] lvl_out
);

  import breakout_pkg::*;

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STAB_W = $clog2(LVL_STABLE + 1) > 0 ? $clog2(LVL_STABLE + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LVL_STABLE);
  localparam logic [POS_W-1:0]  PX_MAX   = POS_W'(SCREEN_W - PADDLE_W);
  localparam logic [POS_W-1:0]  PX_HOME  = POS_W'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [POS_W-1:0]  STEP_PX  = POS_W'(STEP);

  logic [LVL_W+1:0]  sync_q;
  logic              left_s;
  logic              right_s;
  logic [LVL_W-1:0]  lvl_s;
  logic              left_d;
  logic              right_d;
  logic [LVL_W-1:0]  lvl_prev;
  logic [CNT_W-1:0]  tick_cnt;
  logic [1:0]        dir;
  logic [1:0]        dir_next;
  logic [STAB_W-1:0] stab_cnt;
  logic              lvl_commit;

  input_sync #(.WIDTH(LVL_W + 2)) u_input_sync (
    .clk   (CLK),
    .rst_n (CPU_RESETN),
    .d     ({level, move_right, move_left}),
    .q     (sync_q)
  );

  assign left_s  = sync_q[0];
  assign right_s = sync_q[1];
  assign lvl_s   = sync_q[LVL_W+1:2];

  // Previous synchronized values feed key-press edge detection and level stability.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      left_d   <= 1'b0;
      right_d  <= 1'b0;
      lvl_prev <= '0;
    end else begin
      left_d   <= left_s;
      right_d  <= right_s;
      lvl_prev <= lvl_s;
    end
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign frame_tick = (tick_cnt == CNT_LAST);

  // NOTE: dir_next gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dir_next = dir;
    case (dir)
      DIR_IDLE: begin
        if (left_s && !right_s)      dir_next = DIR_LEFT;
        else if (right_s && !left_s) dir_next = DIR_RIGHT;
      end
      DIR_LEFT: begin
        if (!left_s)                 dir_next = right_s ? DIR_RIGHT : DIR_IDLE;
        else if (right_s && !right_d) dir_next = DIR_RIGHT;
      end
      DIR_RIGHT: begin
        if (!right_s)                dir_next = left_s ? DIR_LEFT : DIR_IDLE;
        else if (left_s && !left_d)  dir_next = DIR_LEFT;
      end
      default: dir_next = DIR_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      dir <= DIR_IDLE;
    end else begin
      dir <= dir_next;
    end
  end

  // Saturating moves: compare before stepping so the unsigned position never wraps.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      paddle_x <= PX_HOME;
    end else if (frame_tick && game_running) begin
      if (dir == DIR_LEFT) begin
        paddle_x <= (paddle_x < STEP_PX) ? '0 : paddle_x - STEP_PX;
      end else if (dir == DIR_RIGHT) begin
        paddle_x <= (paddle_x >= PX_MAX - STEP_PX) ? PX_MAX : paddle_x + STEP_PX;
      end
    end
  end

  // Stability count keeps running during play so a held choice commits as soon as play stops.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      stab_cnt <= '0;
    end else if (!lvl_valid(lvl_s) || (lvl_s != lvl_prev)) begin
      stab_cnt <= '0;
    end else if (frame_tick && (stab_cnt != STAB_MAX)) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign lvl_commit = (stab_cnt == STAB_MAX) && (lvl_s == lvl_prev) && lvl_valid(lvl_s) &&
                      (lvl_s != lvl_out) && !game_running;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      lvl_out <= LVL_MIN;
      lvl_req <= 1'b0;
    end else if (lvl_req) begin
      if (lvl_ack) lvl_req <= 1'b0;
    end else if (lvl_commit) begin
      lvl_out <= lvl_s;
      lvl_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Randomized and directed bench for paddle_input_ctrl against a behavioural
// model built from key-press times, tick arithmetic and level hold times.
module tb_paddle_input_ctrl;

  localparam int T       = 10;
  localparam int STEP    = 4;
  localparam int STABLE  = 3;
  localparam int PX_MAX  = 576;
  localparam int PX_HOME = 288;

  logic       CLK = 1'b0;
  logic       CPU_RESETN = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic [3:0] level = 4'd0;
  logic       game_running = 1'b0;
  logic       lvl_ack = 1'b0;
  logic [9:0] paddle_x;
  logic       frame_tick;
  logic       lvl_req;
  logic [3:0] lvl_out;

  paddle_input_ctrl #(
    .TICK_DIV   (T),
    .SCREEN_W   (640),
    .PADDLE_W   (64),
    .STEP       (STEP),
    .LVL_STABLE (STABLE)
  ) dut (
    .CLK          (CLK),
    .CPU_RESETN   (CPU_RESETN),
    .move_left    (move_left),
    .move_right   (move_right),
    .level        (level),
    .game_running (game_running),
    .lvl_ack      (lvl_ack),
    .paddle_x     (paddle_x),
    .frame_tick   (frame_tick),
    .lvl_req      (lvl_req),
    .lvl_out      (lvl_out)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Stimulus for the current cycle
  bit cur_l, cur_r, cur_run, cur_ack;
  int cur_lvl;
  int n;

  // Reference model state
  typedef enum int {M_IDLE, M_LEFT, M_RIGHT} mdir_e;
  mdir_e m_dir;
  int    m_px;
  int    m_lvl_out;
  bit    m_req;
  int    hl[3], hr[3], hv[3];   // raw inputs 1, 2 and 3 cycles ago
  int    press_l, press_r;      // cycle at which each synchronized key went down
  int    run_start;             // cycle at which the synchronized level last changed

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic int ticks_in(input int a, input int b);
    if (b < a) return 0;
    return (b + 1) / T - a / T;
  endfunction

  task automatic model_reset();
    m_dir = M_IDLE;
    m_px = PX_HOME;
    m_lvl_out = 1;
    m_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hl[i] = 0; hr[i] = 0; hv[i] = 0;
    end
    press_l = -1;
    press_r = -1;
    run_start = 0;
  endtask

  task automatic model_update();
    int    sl, sr, sv;
    mdir_e nd;
    int    npx, nlo;
    bit    nreq;
    sl = hl[1]; sr = hr[1]; sv = hv[1];
    npx = m_px; nlo = m_lvl_out; nreq = m_req;
    if (sl != 0 && hl[2] == 0) press_l = n;
    if (sr != 0 && hr[2] == 0) press_r = n;
    if (sv != hv[2]) run_start = n;

    if ((n % T == T - 1) && cur_run) begin
      if (m_dir == M_LEFT)       npx = (m_px - STEP < 0) ? 0 : m_px - STEP;
      else if (m_dir == M_RIGHT) npx = (m_px + STEP > PX_MAX) ? PX_MAX : m_px + STEP;
    end

    // Last key pressed wins; a simultaneous press of both keys means no motion.
    if (sl != 0 && sr != 0)
      nd = (press_l > press_r) ? M_LEFT : (press_r > press_l) ? M_RIGHT : M_IDLE;
    else if (sl != 0) nd = M_LEFT;
    else if (sr != 0) nd = M_RIGHT;
    else              nd = M_IDLE;

    if (m_req) begin
      if (cur_ack) nreq = 1'b0;
    end else if (!cur_run && sv >= 1 && sv <= 8 && sv != m_lvl_out &&
                 ticks_in(run_start + 1, n - 1) >= STABLE) begin
      nlo = sv;
      nreq = 1'b1;
    end

    m_dir = nd; m_px = npx; m_lvl_out = nlo; m_req = nreq;
    hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = int'(cur_l);
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = int'(cur_r);
    hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = cur_lvl;
  endtask

  task automatic drive();
    move_left = cur_l;
    move_right = cur_r;
    level = 4'(cur_lvl);
    game_running = cur_run;
    lvl_ack = cur_ack;
  endtask

  task automatic step();
    drive();
    @(negedge CLK);
    check("frame_tick", 32'(frame_tick), 32'((n % T) == (T - 1)));
    check("paddle_x", 32'(paddle_x), m_px);
    check("lvl_req", 32'(lvl_req), 32'(m_req));
    check("lvl_out", 32'(lvl_out), m_lvl_out);
    model_update();
    @(posedge CLK);
    #1;
    n++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    CPU_RESETN = 1'b0;
    drive();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_paddle_x", 32'(paddle_x), PX_HOME);
    check("rst_frame_tick", 32'(frame_tick), 0);
    check("rst_lvl_req", 32'(lvl_req), 0);
    check("rst_lvl_out", 32'(lvl_out), 1);
    model_reset();
    n = 0;
    CPU_RESETN = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int guard = 0;
    while (!m_req && guard < 200) begin
      step();
      guard++;
    end
    check(tag, 32'(lvl_req), 1);
  endtask

  // Async reset in the middle of a tick cycle with a request pending.
  task automatic reset_mid();
    int guard = 0;
    while ((n % T) != (T - 1) && guard < 2 * T) begin
      step();
      guard++;
    end
    drive();
    @(negedge CLK);
    check("pre_rst_tick", 32'(frame_tick), 1);
    check("pre_rst_req", 32'(lvl_req), 1);
    check("pre_rst_px", 32'(paddle_x), 100);
    #2;
    CPU_RESETN = 1'b0;
    #1;
    check("mid_rst_tick", 32'(frame_tick), 0);
    check("mid_rst_req", 32'(lvl_req), 0);
    check("mid_rst_lvl_out", 32'(lvl_out), 1);
    check("mid_rst_px", 32'(paddle_x), PX_HOME);
    @(posedge CLK);
    #1;
    model_reset();
    n = 0;
    CPU_RESETN = 1'b1;
  endtask

  initial begin
    int guard;
    cur_l = 0; cur_r = 0; cur_run = 0; cur_ack = 0; cur_lvl = 0;
    n = 0;

    // Left held from reset while playing: walk down to 0 and stay there.
    cur_l = 1; cur_run = 1;
    do_reset();
    steps(820);
    check("left_sat", 32'(paddle_x), 0);

    // Right held, left pressed on top, left released: right wins again, then saturate.
    cur_l = 0; cur_r = 1;
    steps(5);
    cur_l = 1;
    steps(40);
    cur_l = 0;
    steps(1600);
    check("right_sat", 32'(paddle_x), PX_MAX);

    // Out-of-range levels are ignored.
    cur_r = 0; cur_run = 0;
    cur_lvl = 12;
    steps(60);
    check("lvl12_no_req", 32'(lvl_req), 0);
    cur_lvl = 0;
    steps(60);
    check("lvl0_no_req", 32'(lvl_req), 0);
    check("lvl0_out", 32'(lvl_out), 1);

    // Ack without a pending request is ignored.
    cur_ack = 1;
    steps(10);
    cur_ack = 0;

    // A level chosen during play is only requested once play stops.
    cur_lvl = 3; cur_run = 1;
    steps(80);
    check("lvl3_running", 32'(lvl_req), 0);
    cur_run = 0;
    wait_req("lvl3_req");
    check("lvl3_out", 32'(lvl_out), 3);
    cur_ack = 1;
    step();
    cur_ack = 0;
    check("lvl3_ack_clear", 32'(lvl_req), 0);

    // Level 5: request held with lvl_out frozen until acknowledged.
    cur_lvl = 5;
    wait_req("lvl5_req");
    cur_lvl = 7;
    steps(40);
    check("lvl5_held_req", 32'(lvl_req), 1);
    check("lvl5_held_out", 32'(lvl_out), 5);
    cur_ack = 1;
    step();
    cur_ack = 0;
    check("lvl5_ack_clear", 32'(lvl_req), 0);
    steps(60);

    // Pending request survives game start; move to x=100 and reset mid-tick.
    cur_lvl = 6;
    wait_req("lvl6_req");
    cur_run = 1; cur_l = 1;
    guard = 0;
    while (m_px != 100 && guard < 3000) begin
      step();
      guard++;
    end
    cur_run = 0; cur_l = 0;
    steps(5);
    check("lvl6_kept", 32'(lvl_req), 1);
    reset_mid();

    // Randomized play.
    cur_l = 0; cur_r = 0; cur_run = 0; cur_ack = 0; cur_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) cur_l = ~cur_l;
      if ($urandom_range(0, 7) == 0) cur_r = ~cur_r;
      if ($urandom_range(0, 99) == 0) cur_run = ~cur_run;
      if ($urandom_range(0, 39) == 0)
        cur_lvl = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 8)) : int'($urandom_range(9, 16)) % 16;
      cur_ack = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
